// File: rtl/hack_alu_mul_seq_if.sv
// rtl/hack_alu_mul_seq_if.sv - request/result bundle for the shift-and-add multiplier sequencer
interface hack_alu_mul_seq_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        zr;
  logic        ng;

  modport master (
    output start, a, b,
    input  busy, done, product, zr, ng
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, zr, ng
  );
endinterface

// File: rtl/hack_alu_mul_seq.sv
// rtl/hack_alu_mul_seq.sv - Hack-style ALU plus a sequencer that time-shares it for 16-bit shift-and-add multiply
module alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_f;

  always_comb begin
    w_x = zx ? 16'h0000 : x;
    w_x = nx ? ~w_x : w_x;
    w_y = zy ? 16'h0000 : y;
    w_y = ny ? ~w_y : w_y;
    w_f = f ? (w_x + w_y) : (w_x & w_y);
    out = no ? ~w_f : w_f;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end
endmodule

module hack_alu_mul_seq (
  input  logic                     clk,
  input  logic                     rst_n,
  hack_alu_mul_seq_if.slave        bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DBL, S_DONE} state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [15:0] r_mplr;
  logic        r_busy;
  logic        r_done;

  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [5:0]  w_ctrl;
  logic [15:0] w_out;
  logic        w_zr;
  logic        w_ng;

  // Control vector order: zx nx zy ny f no
  always_comb begin
    w_x    = r_acc;
    w_y    = r_mcand;
    w_ctrl = 6'b101010;
    case (r_state)
      S_ADD:  w_ctrl = 6'b000010;
      S_DBL: begin
        w_x    = r_mcand;
        w_ctrl = 6'b000010;
      end
      S_DONE: w_ctrl = 6'b001100;
      default: w_ctrl = 6'b101010;
    endcase
  end

  alu u_alu (
    .x   (w_x),
    .y   (w_y),
    .zx  (w_ctrl[5]),
    .nx  (w_ctrl[4]),
    .zy  (w_ctrl[3]),
    .ny  (w_ctrl[2]),
    .f   (w_ctrl[1]),
    .no  (w_ctrl[0]),
    .out (w_out),
    .zr  (w_zr),
    .ng  (w_ng)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 16'h0000;
      r_mcand <= 16'h0000;
      r_mplr  <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= 16'h0000;
            r_mcand <= bus.a;
            r_mplr  <= bus.b;
            r_busy  <= 1'b1;
            if (bus.b != 16'h0000) begin
              r_state <= S_ADD;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_ADD: begin
          if (r_mplr[0]) r_acc <= w_out;
          r_state <= S_DBL;
        end
        S_DBL: begin
          r_mcand <= w_out;
          r_mplr  <= {1'b0, r_mplr[15:1]};
          // Stop as soon as no multiplier bits remain above the one just consumed
          if (r_mplr[15:1] == 15'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_acc;
  assign bus.zr      = w_zr;
  assign bus.ng      = w_ng;
endmodule
